// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - shared types and constants for the UART I/O controller
package uart_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } tx_state_e;

    localparam logic [31:0] RX_EMPTY_VALUE = 32'hFFFF_FFFF;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_io_ctrl_if.sv
// rtl/uart_io_ctrl_if.sv - datapath and serial-core signals of the UART I/O controller
interface uart_io_ctrl_if;

    logic        uart_write_en;
    logic [7:0]  tx_wdata;
    logic        uart_read_en;
    logic [31:0] read_data;
    logic        flag_clr;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_full;
    logic        rx_empty;
    logic        tx_drop;
    logic        rx_overrun;

    modport master (
        input  uart_write_en, tx_wdata, uart_read_en, flag_clr,
        input  tx_ready, rx_valid, rx_byte,
        output read_data, tx_valid, tx_byte,
        output tx_full, rx_empty, tx_drop, rx_overrun
    );

    modport slave (
        output uart_write_en, tx_wdata, uart_read_en, flag_clr,
        output tx_ready, rx_valid, rx_byte,
        input  read_data, tx_valid, tx_byte,
        input  tx_full, rx_empty, tx_drop, rx_overrun
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with a head output readable without popping
module sync_fifo
    import uart_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              head,
    output logic                          full,
    output logic                          empty,
    output logic [ptr_width(DEPTH):0]     count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - TX/RX byte buffering between the datapath and the UART serial cores
// Optional internal TX-to-RX loopback is enabled by defining UART_LOOPBACK_EN.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
`ifdef UART_LOOPBACK_EN
    input  logic loopback,
`endif
    uart_io_ctrl_if.master bus
);

    localparam int TX_CW    = ptr_width(TX_DEPTH) + 1;
    localparam int RX_CW    = ptr_width(RX_DEPTH) + 1;
    localparam int GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    tx_state_e        state_q, state_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             tx_pop;
    logic             tx_accept;

    logic [7:0]       tx_head;
    logic             tx_full_i;
    logic             tx_empty_i;
    logic [TX_CW-1:0] tx_count;

    logic             rx_push;
    logic [7:0]       rx_wdata;
    logic             rx_pop;
    logic [7:0]       rx_head;
    logic             rx_full_i;
    logic             rx_empty_i;
    logic [RX_CW-1:0] rx_count;

    logic             tx_drop_evt;
    logic             rx_overrun_evt;
    logic             tx_drop_q;
    logic             rx_overrun_q;

`ifdef UART_LOOPBACK_EN
    // In loopback the offered byte is consumed internally and written into RX.
    assign tx_accept    = tx_valid_q & (loopback | bus.tx_ready);
    assign bus.tx_valid = tx_valid_q & ~loopback;
    assign rx_push      = loopback ? tx_accept : bus.rx_valid;
    assign rx_wdata     = loopback ? tx_byte_q : bus.rx_byte;
`else
    assign tx_accept    = tx_valid_q & bus.tx_ready;
    assign bus.tx_valid = tx_valid_q;
    assign rx_push      = bus.rx_valid;
    assign rx_wdata     = bus.rx_byte;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.uart_write_en),
        .pop   (tx_pop),
        .wdata (bus.tx_wdata),
        .head  (tx_head),
        .full  (tx_full_i),
        .empty (tx_empty_i),
        .count (tx_count)
    );

    assign rx_pop = bus.uart_read_en & ~rx_empty_i;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_wdata),
        .head  (rx_head),
        .full  (rx_full_i),
        .empty (rx_empty_i),
        .count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // The IDLE cycle that follows GAP is the last inter-byte idle cycle, so GAP
    // itself lasts GAP_CYCLES-1 cycles.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        gap_cnt_d  = gap_cnt_q;
        tx_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tx_empty_i) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_head;
                    tx_valid_d = 1'b1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYCLES > 1) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = IDLE;
                else                               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_drop_evt    = bus.uart_write_en & tx_full_i & ~tx_pop;
    assign rx_overrun_evt = rx_push & rx_full_i & ~rx_pop;

    // A new event in the clearing cycle wins over flag_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_drop_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_drop_q    <= (tx_drop_q & ~bus.flag_clr) | tx_drop_evt;
            rx_overrun_q <= (rx_overrun_q & ~bus.flag_clr) | rx_overrun_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (tx_count <= TX_CW'(TX_DEPTH));
            assert (rx_count <= RX_CW'(RX_DEPTH));
        end
    end

    assign bus.tx_byte    = tx_byte_q;
    assign bus.read_data  = rx_empty_i ? RX_EMPTY_VALUE : {24'h0, rx_head};
    assign bus.tx_full    = tx_full_i;
    assign bus.rx_empty   = rx_empty_i;
    assign bus.tx_drop    = tx_drop_q;
    assign bus.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb/tb_uart_io_ctrl.sv - self-checking bench for uart_io_ctrl (back-to-back and 3-cycle gap builds)
module tb_uart_io_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    uart_io_ctrl_if if0 ();
    uart_io_ctrl_if if3 ();

    always #5 clk = ~clk;

    uart_io_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .GAP_CYCLES(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
`ifdef UART_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .bus      (if0.master)
    );

    uart_io_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .GAP_CYCLES(3)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
`ifdef UART_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .bus      (if3.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // TX scoreboard: every handshake on the GAP_CYCLES=0 instance must match the queue head.
    always @(negedge clk) begin
        if (!reset && if0.tx_valid === 1'b1 && if0.tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL tx_unexpected: observed byte %h expected none", if0.tx_byte);
            end else begin
                chk("tx_byte_order", {24'h0, if0.tx_byte}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] exp_b;
        logic       gap_pat [5];
        int         budget;

        gap_pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        {if0.uart_write_en, if0.tx_wdata, if0.uart_read_en, if0.flag_clr} = '0;
        {if0.tx_ready, if0.rx_valid, if0.rx_byte} = '0;
        {if3.uart_write_en, if3.tx_wdata, if3.uart_read_en, if3.flag_clr} = '0;
        {if3.tx_ready, if3.rx_valid, if3.rx_byte} = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();

        chk("rst_tx_valid",   {31'h0, if0.tx_valid},   32'h0);
        chk("rst_tx_byte",    {24'h0, if0.tx_byte},    32'h0);
        chk("rst_tx_full",    {31'h0, if0.tx_full},    32'h0);
        chk("rst_rx_empty",   {31'h0, if0.rx_empty},   32'h1);
        chk("rst_read_data",  if0.read_data,           32'hFFFF_FFFF);
        chk("rst_tx_drop",    {31'h0, if0.tx_drop},    32'h0);
        chk("rst_rx_overrun", {31'h0, if0.rx_overrun}, 32'h0);

        // Single byte latency: write at N, valid for exactly one cycle at N+2.
        if0.tx_ready = 1'b1;
        if0.uart_write_en = 1'b1; if0.tx_wdata = 8'h41; tx_q.push_back(8'h41);
        step();
        if0.uart_write_en = 1'b0;
        chk("lat_n1_valid", {31'h0, if0.tx_valid}, 32'h0);
        step();
        chk("lat_n2_valid", {31'h0, if0.tx_valid}, 32'h1);
        chk("lat_n2_byte",  {24'h0, if0.tx_byte},  32'h41);
        step();
        chk("lat_n3_valid", {31'h0, if0.tx_valid}, 32'h0);

        // Back-to-back: one byte per two cycles.
        if0.uart_write_en = 1'b1; if0.tx_wdata = 8'h42; tx_q.push_back(8'h42);
        step();
        if0.tx_wdata = 8'h43; tx_q.push_back(8'h43);
        step();
        if0.uart_write_en = 1'b0;
        chk("b2b_valid0", {31'h0, if0.tx_valid}, 32'h1);
        chk("b2b_byte0",  {24'h0, if0.tx_byte},  32'h42);
        step();
        chk("b2b_valid1", {31'h0, if0.tx_valid}, 32'h0);
        step();
        chk("b2b_valid2", {31'h0, if0.tx_valid}, 32'h1);
        chk("b2b_byte2",  {24'h0, if0.tx_byte},  32'h43);
        step();
        chk("b2b_valid3", {31'h0, if0.tx_valid}, 32'h0);

        // Fill TX with the core stalled: 0x00 presented, 0x01..0x10 queued, 0x11 dropped.
        if0.tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if0.uart_write_en = 1'b1;
            if0.tx_wdata = 8'(i);
            if (i <= 16) tx_q.push_back(8'(i));
            step();
            if (i == 16) begin
                chk("fill_tx_full", {31'h0, if0.tx_full}, 32'h1);
                chk("fill_no_drop", {31'h0, if0.tx_drop}, 32'h0);
            end
        end
        if0.uart_write_en = 1'b0;
        chk("fill_drop",       {31'h0, if0.tx_drop},  32'h1);
        chk("fill_head_valid", {31'h0, if0.tx_valid}, 32'h1);
        chk("fill_head_byte",  {24'h0, if0.tx_byte},  32'h00);
        repeat (3) step();
        chk("drop_sticky", {31'h0, if0.tx_drop}, 32'h1);
        if0.tx_ready = 1'b1;
        budget = 0;
        while (tx_q.size() != 0 && budget < 200) begin
            step();
            budget++;
        end
        chk("tx_drain_left", tx_q.size(), 32'h0);
        step();
        chk("drain_tx_full", {31'h0, if0.tx_full}, 32'h0);
        if0.flag_clr = 1'b1;
        step();
        if0.flag_clr = 1'b0;
        chk("drop_cleared", {31'h0, if0.tx_drop}, 32'h0);

        // Inter-byte gap on the GAP_CYCLES=3 instance.
        if3.tx_ready = 1'b1;
        if3.uart_write_en = 1'b1; if3.tx_wdata = 8'hA1;
        step();
        if3.tx_wdata = 8'hA2;
        chk("gap_n1_valid", {31'h0, if3.tx_valid}, 32'h0);
        step();
        if3.uart_write_en = 1'b0;
        chk("gap_b1_valid", {31'h0, if3.tx_valid}, 32'h1);
        chk("gap_b1_byte",  {24'h0, if3.tx_byte},  32'hA1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("gap_c%0d_valid", i + 1), {31'h0, if3.tx_valid}, {31'h0, gap_pat[i]});
            if (i == 3) chk("gap_b2_byte", {24'h0, if3.tx_byte}, 32'hA2);
        end

        // RX single byte, then read of an empty FIFO.
        if0.rx_valid = 1'b1; if0.rx_byte = 8'h5A; rx_q.push_back(8'h5A);
        step();
        if0.rx_valid = 1'b0;
        if0.uart_read_en = 1'b1;
        #1;
        chk("rx_read_5a",     if0.read_data, {24'h0, rx_q.pop_front()});
        chk("rx_not_empty",   {31'h0, if0.rx_empty}, 32'h0);
        step();
        if0.uart_read_en = 1'b0;
        chk("rx_empty_after", {31'h0, if0.rx_empty}, 32'h1);
        if0.uart_read_en = 1'b1;
        #1;
        chk("rx_read_empty",  if0.read_data, 32'hFFFF_FFFF);
        step();
        if0.uart_read_en = 1'b0;
        chk("rx_still_empty", {31'h0, if0.rx_empty}, 32'h1);

        // Overrun on the 17th unread byte.
        for (int i = 0; i < 17; i++) begin
            if0.rx_valid = 1'b1;
            if0.rx_byte = 8'h80 + 8'(i);
            if (i < 16) rx_q.push_back(8'h80 + 8'(i));
            step();
            if (i == 15) chk("rx_16_no_overrun", {31'h0, if0.rx_overrun}, 32'h0);
        end
        if0.rx_valid = 1'b0;
        chk("rx_overrun", {31'h0, if0.rx_overrun}, 32'h1);

        // An overrun coinciding with flag_clr keeps the flag set.
        if0.flag_clr = 1'b1; if0.rx_valid = 1'b1; if0.rx_byte = 8'hEE;
        step();
        if0.flag_clr = 1'b0; if0.rx_valid = 1'b0;
        chk("overrun_vs_clr", {31'h0, if0.rx_overrun}, 32'h1);
        if0.flag_clr = 1'b1;
        step();
        if0.flag_clr = 1'b0;
        chk("overrun_cleared", {31'h0, if0.rx_overrun}, 32'h0);

        // Full RX with simultaneous push and pop.
        if0.rx_valid = 1'b1; if0.rx_byte = 8'h77; if0.uart_read_en = 1'b1;
        #1;
        exp_b = rx_q.pop_front();
        rx_q.push_back(8'h77);
        chk("rx_pp_head", if0.read_data, {24'h0, exp_b});
        step();
        if0.rx_valid = 1'b0; if0.uart_read_en = 1'b0;
        chk("rx_pp_no_overrun", {31'h0, if0.rx_overrun}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if0.uart_read_en = 1'b1;
            #1;
            chk($sformatf("rx_drain_%0d", i), if0.read_data, {24'h0, rx_q.pop_front()});
            step();
        end
        if0.uart_read_en = 1'b0;
        chk("rx_drain_empty", {31'h0, if0.rx_empty}, 32'h1);
        chk("rx_drain_data",  if0.read_data,         32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
